// File: rtl/fifo_arb_pkg.sv
// ============================================================================
// fifo_arb_pkg : shared types and helpers for the FIFO write-port arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_t;

   // Index width that stays at least one bit even for tiny requester counts.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ============================================================================
// rr_pick : combinational rotating-priority picker (search starts after last_i)
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = clog2_min1(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    last_i,
   output logic [ID_W-1:0]    winner_o,
   output logic               any_o
);

   int idx;

   always_comb begin
      winner_o = '0;
      any_o    = 1'b0;
      idx      = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = (int'(last_i) + i) % NUM_REQ;
         if (!any_o && req_i[idx]) begin
            any_o    = 1'b1;
            winner_o = ID_W'(idx);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// fifo_wr_arbiter : round-robin burst scheduler for a shared FIFO write port
// Optional source tag on write data: define FIFO_ARB_TAG_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int NUM_REQ   = 4,
   parameter  int DATA_W    = 8,
   parameter  int MAX_BURST = 4,
   localparam int ID_W      = clog2_min1(NUM_REQ),
`ifdef FIFO_ARB_TAG_EN
   localparam int WR_W      = DATA_W + ID_W
`else
   localparam int WR_W      = DATA_W
`endif
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [NUM_REQ-1:0]        i_req,
   input  logic [NUM_REQ*DATA_W-1:0] i_data,
   output logic [NUM_REQ-1:0]        o_ready,
   output logic                      o_wren,
   output logic [WR_W-1:0]           o_wrdata,
   input  logic                      i_full,
   input  logic                      i_alm_full,
   output logic [ID_W-1:0]           o_gnt_id,
   output logic                      o_busy
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   arb_state_t        state_q, state_d;
   logic [ID_W-1:0]   gnt_q, gnt_d;
   logic [ID_W-1:0]   last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ID_W-1:0]   pick_id;
   logic              pick_any;
   logic              gnt_req;
   logic [DATA_W-1:0] gnt_data;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_i    (i_req),
      .last_i   (last_q),
      .winner_o (pick_id),
      .any_o    (pick_any)
   );

   assign gnt_req  = i_req[gnt_q];
   assign gnt_data = i_data[int'(gnt_q)*DATA_W +: DATA_W];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ARB_IDLE;
         gnt_q   <= '0;
         last_q  <= ID_W'(NUM_REQ - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      o_ready  = '0;
      o_wren   = 1'b0;
      o_wrdata = '0;
      case (state_q)
         ARB_IDLE: begin
            // Arbitration costs one cycle; beats are only taken in BURST.
            if (pick_any && !i_full && !i_alm_full) begin
               gnt_d   = pick_id;
               last_d  = pick_id;
               cnt_d   = '0;
               state_d = ARB_BURST;
            end
         end
         ARB_BURST: begin
            o_ready[gnt_q] = !i_full;
            o_wren         = gnt_req && !i_full;
`ifdef FIFO_ARB_TAG_EN
            o_wrdata       = {gnt_q, gnt_data};
`else
            o_wrdata       = gnt_data;
`endif
            if (o_wren) begin
               if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
                  cnt_d   = '0;
                  state_d = ARB_IDLE;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
               end
            end else if (!gnt_req) begin
               cnt_d   = '0;
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   assign o_gnt_id = gnt_q;
   assign o_busy   = (state_q == ARB_BURST);

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// tb_fifo_wr_arbiter : scoreboard bench with a cycle-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int DATA_W    = 8;
   localparam int MAX_BURST = 4;
`ifdef FIFO_ARB_TAG_EN
   localparam int WR_W      = DATA_W + 2;
`else
   localparam int WR_W      = DATA_W;
`endif

   logic                      clk = 1'b0;
   logic                      rstn;
   logic [NUM_REQ-1:0]        i_req;
   logic [NUM_REQ*DATA_W-1:0] i_data;
   logic [NUM_REQ-1:0]        o_ready;
   logic                      o_wren;
   logic [WR_W-1:0]           o_wrdata;
   logic                      i_full;
   logic                      i_alm_full;
   logic [1:0]                o_gnt_id;
   logic                      o_busy;

   fifo_wr_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .DATA_W    (DATA_W),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .i_req      (i_req),
      .i_data     (i_data),
      .o_ready    (o_ready),
      .o_wren     (o_wren),
      .o_wrdata   (o_wrdata),
      .i_full     (i_full),
      .i_alm_full (i_alm_full),
      .o_gnt_id   (o_gnt_id),
      .o_busy     (o_busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [WR_W-1:0] exp_q[$];
   int              seq[NUM_REQ];
   bit              tag_mode;
   logic [7:0]      tag_val;

   // Reference model: who holds the port, who won last, beats taken so far.
   bit m_busy;
   int m_hold;
   int m_last;
   int m_beats;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [WR_W-1:0] wrval(input int id, input logic [7:0] d);
`ifdef FIFO_ARB_TAG_EN
      return {2'(id), d};
`else
      return WR_W'(d);
`endif
   endfunction

   task automatic model_reset();
      m_busy  = 1'b0;
      m_hold  = 0;
      m_last  = NUM_REQ - 1;
      m_beats = 0;
   endtask

   task automatic step(input logic [3:0] req, input bit full, input bit alm);
      logic [3:0] exp_ready;
      logic [7:0] cur[NUM_REQ];
      @(negedge clk);
      for (int k = 0; k < NUM_REQ; k++) begin
         cur[k] = (tag_mode && k == 2) ? tag_val : {2'(k), 6'(seq[k])};
         i_data[k*DATA_W +: DATA_W] = cur[k];
      end
      i_req      = req;
      i_full     = full;
      i_alm_full = alm;
      #1;
      chk("busy", 32'(o_busy), 32'(m_busy));
      if (m_busy) chk("gnt_id", 32'(o_gnt_id), 32'(m_hold));
      exp_ready = '0;
      if (m_busy) begin
         if (!full) exp_ready[m_hold] = 1'b1;
         if (req[m_hold] && !full) begin
            exp_q.push_back(wrval(m_hold, cur[m_hold]));
            seq[m_hold]++;
            m_beats++;
            if (m_beats == MAX_BURST) m_busy = 1'b0;
         end else if (!req[m_hold]) begin
            m_busy = 1'b0;
         end
      end else if (req != 0 && !full && !alm) begin
         for (int o = 1; o <= NUM_REQ; o++) begin
            int c;
            c = (m_last + o) % NUM_REQ;
            if (req[c]) begin
               m_hold = c;
               break;
            end
         end
         m_last  = m_hold;
         m_busy  = 1'b1;
         m_beats = 0;
      end
      chk("ready", 32'(o_ready), 32'(exp_ready));
   endtask

   // Monitor: every FIFO write must match the oldest expected write.
   always @(negedge clk) begin
      logic [WR_W-1:0] e;
      #2;
      if (o_wren) begin
         chk("wren_while_full", 32'(i_full), 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=%0h expected=none at %0t", o_wrdata, $time);
         end else begin
            e = exp_q.pop_front();
            chk("wrdata", 32'(o_wrdata), 32'(e));
         end
      end
   end

   initial begin
      rstn       = 1'b0;
      i_req      = 4'hF;
      i_data     = '0;
      i_full     = 1'b0;
      i_alm_full = 1'b0;
      tag_mode   = 1'b0;
      tag_val    = 8'h00;
      for (int k = 0; k < NUM_REQ; k++) seq[k] = 0;
      model_reset();

      repeat (2) @(negedge clk);
      #1;
      chk("rst_ready",  32'(o_ready),  32'd0);
      chk("rst_wren",   32'(o_wren),   32'd0);
      chk("rst_busy",   32'(o_busy),   32'd0);
      chk("rst_gnt_id", 32'(o_gnt_id), 32'd0);
      chk("rst_wrdata", 32'(o_wrdata), 32'd0);
      i_req = 4'h0;
      @(negedge clk);
      rstn = 1'b1;

      // Fairness with all requesters active
      repeat (22) step(4'hF, 1'b0, 1'b0);

      // Early end: requester drops mid-burst
      repeat (3) step(4'h0, 1'b0, 1'b0);
      step(4'h3, 1'b0, 1'b0);
      step(4'h3, 1'b0, 1'b0);
      step(4'h3, 1'b0, 1'b0);
      repeat (6) step(4'h2, 1'b0, 1'b0);

      // Backpressure mid-burst
      repeat (3) step(4'h0, 1'b0, 1'b0);
      repeat (3) step(4'hF, 1'b0, 1'b0);
      repeat (3) step(4'hF, 1'b1, 1'b0);
      repeat (6) step(4'hF, 1'b0, 1'b0);

      // Almost-full blocks only new grants
      repeat (3) step(4'h0, 1'b0, 1'b0);
      repeat (4) step(4'h2, 1'b0, 1'b1);
      repeat (4) step(4'h2, 1'b0, 1'b0);

      // Fixed payload on requester 2
      repeat (3) step(4'h0, 1'b0, 1'b0);
      tag_mode = 1'b1;
      tag_val  = 8'hA5;
      repeat (4) step(4'h4, 1'b0, 1'b0);
      tag_mode = 1'b0;

      // Reset in the middle of a burst
      repeat (3) step(4'h0, 1'b0, 1'b0);
      repeat (3) step(4'hF, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk("pre_rst_busy", 32'(o_busy), 32'(m_busy));
      rstn = 1'b0;
      #1;
      chk("mid_rst_wren",  32'(o_wren),  32'd0);
      chk("mid_rst_ready", 32'(o_ready), 32'd0);
      chk("mid_rst_busy",  32'(o_busy),  32'd0);
      i_req = 4'h0;
      model_reset();
      @(negedge clk);
      rstn = 1'b1;

      // Randomized traffic
      for (int n = 0; n < 800; n++) begin
         logic [3:0] r;
         for (int k = 0; k < NUM_REQ; k++) r[k] = ($urandom_range(0, 3) != 0);
         step(r, ($urandom_range(0, 6) == 0), ($urandom_range(0, 5) == 0));
      end

      repeat (4) step(4'h0, 1'b0, 1'b0);
      @(negedge clk);
      #3;
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
